// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the iterative multiply / multiply-accumulate sequencer.
package mul_seq_pkg;

  localparam int unsigned MUL_DATA_W = 32;
  localparam int unsigned MUL_CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ZERO = 2'b01,
    ST_ON   = 2'b10,
    ST_END  = 2'b11
  } mul_state_e;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_ADD  = 2'b01;
  localparam logic [1:0] ACC_SUB  = 2'b10;

endpackage

// File: rtl/mul_seq.sv
// Shift-add multiplier with optional HI/LO accumulate; one partial product per clock.
// EX holds start_i high and stalls until ready_o, exactly as for the divider.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned DATA_W = MUL_DATA_W,
  parameter int unsigned CNT_W  = MUL_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_i,
  input  logic [1:0]          accum_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic [2*DATA_W-1:0] hilo_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int unsigned      RES_W    = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  mul_state_e        r_state;
  logic              r_neg;
  logic [1:0]        r_accum;
  logic [RES_W-1:0]  r_hilo;
  logic [RES_W-1:0]  r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [RES_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_neg1;
  logic              w_neg2;
  logic [DATA_W-1:0] w_mag1;
  logic [DATA_W-1:0] w_mag2;
  logic              w_op_zero;
  logic [RES_W-1:0]  w_acc_next;
  logic [RES_W-1:0]  w_prod;
  logic [RES_W-1:0]  w_result;

  // Operand magnitudes at start and the combinational finish adder.
  always_comb begin
    w_neg1     = signed_i & opdata1_i[DATA_W-1];
    w_neg2     = signed_i & opdata2_i[DATA_W-1];
    w_mag1     = w_neg1 ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
    w_mag2     = w_neg2 ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
    w_op_zero  = (opdata1_i == '0) || (opdata2_i == '0);
    w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_prod     = '0;
    if (r_state != ST_ZERO) begin
      w_prod = r_neg ? (~w_acc_next + RES_W'(1)) : w_acc_next;
    end
    case (r_accum)
      ACC_ADD: w_result = r_hilo + w_prod;
      ACC_SUB: w_result = r_hilo - w_prod;
      default: w_result = w_prod;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_neg    <= 1'b0;
      r_accum  <= ACC_NONE;
      r_hilo   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else if (annul_i && (r_state != ST_IDLE)) begin
      // Flush wins over both start_i and a completing step.
      r_state  <= ST_IDLE;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i && !annul_i) begin
            r_accum  <= accum_i;
            r_hilo   <= hilo_i;
            r_neg    <= w_neg1 ^ w_neg2;
            r_mcand  <= RES_W'(w_mag1);
            r_mplier <= w_mag2;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= w_op_zero ? ST_ZERO : ST_ON;
            busy_o   <= !w_op_zero;
          end
        end
        ST_ZERO: begin
          // Two edges here so the zero path reports two cycles after start.
          if (r_cnt == '0) begin
            r_cnt <= CNT_W'(1);
          end else begin
            result_o <= w_result;
            ready_o  <= 1'b1;
            r_state  <= ST_END;
          end
        end
        ST_ON: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            result_o <= w_result;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            r_state  <= ST_END;
          end
        end
        ST_END: begin
          // Result held until EX drops start_i; no restart while it stays high.
          if (!start_i) begin
            r_state  <= ST_IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed-vector bench for mul_seq: stimulus pushes expected results, a monitor checks on ready_o.
module tb_mul_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [1:0]  accum_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] hilo_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .accum_i   (accum_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .hilo_i    (hilo_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  typedef struct {
    string       name;
    logic [63:0] value;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_total   = 0;
  int   n_pass    = 0;
  int   cyc       = 0;
  int   overlap   = 0;
  bit   prev_rdy  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Monitor: pops one expectation on every rising ready_o.
  always @(negedge clk) begin
    if (ready_o && busy_o) overlap++;
    if (ready_o && !prev_rdy) begin
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_result"}, result_o, mon_e.value);
        check({mon_e.name, "_latency"}, 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
      end
    end
    prev_rdy = ready_o;
  end

  task automatic run_op(input string nm, input logic sg, input logic [1:0] ac,
                        input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl,
                        input logic [63:0] exp, input int lat, input int exp_busy, input int hold);
    int busy_cnt;
    int bad;
    bit got;
    busy_cnt = 0;
    bad      = 0;
    got      = 1'b0;
    @(negedge clk);
    signed_i  = sg;
    accum_i   = ac;
    opdata1_i = a;
    opdata2_i = b;
    hilo_i    = hl;
    start_i   = 1'b1;
    sb_q.push_back('{nm, exp, lat, cyc + 1});
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        hilo_i    = {$urandom, $urandom};
        accum_i   = 2'($urandom);
        signed_i  = ~sg;
      end
      if (busy_o) busy_cnt++;
      if (ready_o) got = 1'b1;
    end
    check({nm, "_done"}, 64'(got), 64'(1));
    check({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ready_o !== 1'b1 || result_o !== exp) bad++;
    end
    if (hold > 0) check({nm, "_hold_stable"}, 64'(bad), 64'(0));
    start_i = 1'b0;
    @(negedge clk);
    check({nm, "_idle_ready"}, 64'(ready_o), 64'(0));
    check({nm, "_idle_result"}, result_o, 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    signed_i  = 1'b0;
    accum_i   = 2'b00;
    opdata1_i = '0;
    opdata2_i = '0;
    hilo_i    = '0;
    #3;
    check("reset_result", result_o, 64'(0));
    check("reset_ready", 64'(ready_o), 64'(0));
    check("reset_busy", 64'(busy_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // T1..T4
    run_op("t1_umul", 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,
           64'hFFFFFFFE_00000001, 32, 32, 0);
    run_op("t2_smul", 1'b1, 2'b00, 32'hFFFFFFFD, 32'h00000005, 64'h0,
           64'hFFFFFFFF_FFFFFFF1, 32, 32, 0);
    run_op("t2_smin", 1'b1, 2'b00, 32'h80000000, 32'h80000000, 64'h0,
           64'h40000000_00000000, 32, 32, 0);
    run_op("t3_madd", 1'b1, 2'b01, 32'd2, 32'd3, 64'h00000000_00000010,
           64'h00000000_00000016, 32, 32, 0);
    run_op("t3_msubu", 1'b0, 2'b10, 32'd1, 32'd1, 64'h0,
           64'hFFFFFFFF_FFFFFFFF, 32, 32, 0);
    run_op("t4_zero", 1'b1, 2'b01, 32'd0, 32'd5, 64'h12345678_9ABCDEF0,
           64'h12345678_9ABCDEF0, 2, 0, 0);

    // T5: annul on the 10th ON cycle, then a fresh start
    @(negedge clk);
    signed_i  = 1'b0;
    accum_i   = 2'b00;
    opdata1_i = 32'hFFFFFFFF;
    opdata2_i = 32'hFFFFFFFF;
    start_i   = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_busy_before_annul", 64'(busy_o), 64'(1));
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("t5_annul_ready", 64'(ready_o), 64'(0));
    check("t5_annul_busy", 64'(busy_o), 64'(0));
    check("t5_annul_result", result_o, 64'(0));
    run_op("t5_restart", 1'b0, 2'b00, 32'd7, 32'd6, 64'h0,
           64'h00000000_0000002A, 32, 32, 0);

    // T6A: start held in END
    run_op("t6_hold", 1'b1, 2'b00, 32'hFFFFFFFF, 32'h7FFFFFFF, 64'h0,
           64'hFFFFFFFF_80000001, 32, 32, 5);

    // T6B: asynchronous reset mid-ON
    @(negedge clk);
    signed_i  = 1'b0;
    accum_i   = 2'b00;
    opdata1_i = 32'h12345678;
    opdata2_i = 32'h9ABCDEF0;
    start_i   = 1'b1;
    repeat (5) @(negedge clk);
    check("t6b_busy_before_rst", 64'(busy_o), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("t6b_rst_busy", 64'(busy_o), 64'(0));
    check("t6b_rst_ready", 64'(ready_o), 64'(0));
    check("t6b_rst_result", result_o, 64'(0));
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("t6b_after_rst", 1'b0, 2'b01, 32'h00010000, 32'h00010000, 64'h00000000_00000005,
           64'h00000001_00000005, 32, 32, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    check("ready_busy_exclusive", 64'(overlap), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
